mux8_arbiter: RTL and testbench

Round-robin arbiter that shares one 8:1 bit-select mux among eight requesters. Each cycle it owns the mux select: it picks one pending requester, drives the 3-bit select as a registered output and holds the grant while the owner keeps requesting. A hold limit bounds any single tenure when others are waiting. It sits directly in front of the 8:1 mux; `sel[2]`, `sel[1]` and `sel[0]` connect to the mux's s2, s1 and s0.

---
 rtl/mux8_arbiter_if.sv | 22 ++
 rtl/mux8_arbiter.sv | 99 +++++++++
 tb/tb_mux8_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mux8_arbiter_if.sv
// Request/grant bundle between the eight requesters and the mux8 arbiter.
// master: requesters (drive req); slave: arbiter (drives gnt/sel/valid).
interface mux8_arbiter_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       valid;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  valid
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output valid
  );
endinterface

// File: rtl/mux8_arbiter.sv
// Round-robin owner of an 8:1 mux select with a bounded hold tenure.
// Ports: clk, rst (async high), bus.req in; bus.gnt/sel/valid out (registered).
module mux8_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux8_arbiter_if.slave  bus
);

  localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] LIM = CW'(MAX_HOLD - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [2:0]    owner_q, owner_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [7:0] others;
  logic       rel;

  function automatic logic [2:0] search(
    input logic [7:0] c,
    input logic [2:0] p
  );
    logic [2:0] r;
    logic [2:0] k;
    logic       hit;
    r   = p;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = p + 3'(i);
      if (!hit && c[k]) begin
        r   = k;
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Preemption only fires when the tenure is exhausted and someone else waits.
  assign others = bus.req & ~(8'd1 << owner_q);
  assign rel    = !bus.req[owner_q] || ((cnt_q == LIM) && (others != 8'd0));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 8'd0) begin
          owner_d = search(bus.req, ptr_q);
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!rel) begin
          if (cnt_q != LIM) cnt_d = cnt_q + 1'b1;
        end else begin
          ptr_d = owner_q + 3'd1;
          cnt_d = '0;
          if (others != 8'd0) begin
            owner_d = search(others, owner_q + 3'd1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registers only, so no req->gnt path exists and
  // an async reset clears them at once. sel holds owner while idle.
  always_comb begin
    bus.valid = (state_q == BUSY);
    bus.gnt   = (state_q == BUSY) ? (8'd1 << owner_q) : 8'd0;
    bus.sel   = owner_q;
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Scoreboard bench for mux8_arbiter: MAX_HOLD=4 and MAX_HOLD=1 instances.
// Directed vectors push expectations; a monitor pops and compares.
module tb_mux8_arbiter;

  logic clk;
  logic rst;

  mux8_arbiter_if b4 ();
  mux8_arbiter_if b1 ();

  mux8_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4)
  );

  mux8_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         d1;
    logic [7:0] g;
    logic [2:0] s;
    logic       v;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  bit soak = 0;
  int w4[8];
  int w1[8];
  int max4 = 0;
  int max1 = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] idx(input logic [7:0] g);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
    return r;
  endfunction

  task automatic step4(input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] s, input string nm);
    exp_t x;
    @(negedge clk);
    b4.req = r;
    x.d1 = 1'b0; x.g = g; x.s = s; x.v = |g; x.nm = nm;
    sbq.push_back(x);
    @(posedge clk);
  endtask

  task automatic step1(input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] s, input string nm);
    exp_t x;
    @(negedge clk);
    b1.req = r;
    x.d1 = 1'b1; x.g = g; x.s = s; x.v = |g; x.nm = nm;
    sbq.push_back(x);
    @(posedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.d1) begin
        chk({e.nm, "_gnt"}, 32'(b1.gnt), 32'(e.g));
        chk({e.nm, "_sel"}, 32'(b1.sel), 32'(e.s));
        chk({e.nm, "_vld"}, 32'(b1.valid), 32'(e.v));
      end else begin
        chk({e.nm, "_gnt"}, 32'(b4.gnt), 32'(e.g));
        chk({e.nm, "_sel"}, 32'(b4.sel), 32'(e.s));
        chk({e.nm, "_vld"}, 32'(b4.valid), 32'(e.v));
      end
    end
    chk("onehot4", 32'($onehot0(b4.gnt)), 32'd1);
    chk("onehot1", 32'($onehot0(b1.gnt)), 32'd1);
    chk("vld4", 32'(b4.valid), 32'(|b4.gnt));
    chk("vld1", 32'(b1.valid), 32'(|b1.gnt));
    if (b4.valid) chk("selidx4", 32'(b4.sel), 32'(idx(b4.gnt)));
    if (b1.valid) chk("selidx1", 32'(b1.sel), 32'(idx(b1.gnt)));
    if (soak) begin
      for (int i = 0; i < 8; i++) begin
        if (b4.req[i] && !b4.gnt[i]) w4[i]++;
        else w4[i] = 0;
        if (b1.req[i] && !b1.gnt[i]) w1[i]++;
        else w1[i] = 0;
        if (w4[i] > max4) max4 = w4[i];
        if (w1[i] > max1) max1 = w1[i];
      end
    end
  end

  initial begin
    rst = 1'b1;
    b4.req = 8'h00;
    b1.req = 8'h00;
    #1;
    chk("rst_gnt", 32'(b4.gnt), 32'h0);
    chk("rst_sel", 32'(b4.sel), 32'h0);
    chk("rst_vld", 32'(b4.valid), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single requester 3
    repeat (5) step4(8'h08, 8'h08, 3'd3, "single");
    step4(8'h00, 8'h00, 3'd3, "single_drop");

    // hold limit: owner 0 preempted after its 4th cycle
    repeat (3) step4(8'h01, 8'h01, 3'd0, "hold_own0");
    step4(8'h05, 8'h01, 3'd0, "hold_sat");
    repeat (4) step4(8'h05, 8'h04, 3'd2, "hold_own2");
    step4(8'h05, 8'h01, 3'd0, "hold_back0");
    step4(8'h00, 8'h00, 3'd0, "hold_idle");

    // wrap from owner 7 to 0 without a bubble
    step4(8'h80, 8'h80, 3'd7, "wrap_own7");
    step4(8'h81, 8'h80, 3'd7, "wrap_keep7");
    step4(8'h01, 8'h01, 3'd0, "wrap_to0");
    step4(8'h00, 8'h00, 3'd0, "wrap_idle");

    // async reset mid-grant
    step4(8'h10, 8'h10, 3'd4, "ar_own4");
    step4(8'h10, 8'h10, 3'd4, "ar_hold4");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_gnt", 32'(b4.gnt), 32'h0);
    chk("ar_sel", 32'(b4.sel), 32'h0);
    chk("ar_vld", 32'(b4.valid), 32'h0);
    b4.req = 8'h00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step4(8'hFF, 8'h01, 3'd0, "ar_first");
    step4(8'h00, 8'h00, 3'd0, "ar_idle");

    // rotation with MAX_HOLD=1
    for (int i = 0; i < 9; i++) begin
      step1(8'hFF, 8'd1 << (i % 8), 3'(i % 8), "rot");
    end
    step1(8'h00, 8'h00, 3'd0, "rot_idle");

    // soak with sticky random requests
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      w4[i] = 0;
      w1[i] = 0;
    end
    soak = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) b4.req[i] = ~b4.req[i];
        if ($urandom_range(0, 7) == 0) b1.req[i] = ~b1.req[i];
      end
    end
    @(negedge clk);
    soak = 1'b0;
    chk("fair4", 32'(max4 <= 28), 32'd1);
    chk("fair1", 32'(max1 <= 7), 32'd1);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
